dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for core load/store traffic. Owns a word-addressed data
//   RAM and serves one request at a time over a valid/ready request channel and a
//   valid/ready response channel. Performs RV32I size/sign handling (LB/LH/LW/LBU/LHU,
//   SB/SH/SW) and inserts programmable wait states so the core can be exercised
//   against non-zero-latency memory.
// PARAMETERS
//   DEPTH        1024  number of 32-bit words in the RAM (power of two)
//   WAIT_CYCLES  2     extra cycles between request accept and response (0..15)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   responder can accept a request this cycle
//   req_write    in   1   1 = store, 0 = load
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//   req_funct3   in   3   RV32I load/store funct3 (access size and sign)
//   rsp_valid    out  1   response present
//   rsp_ready    in   1   requester accepts the response
//   rsp_rdata    out  32  load data, sign/zero-extended; 0 for stores and errors
//   rsp_err      out  1   access rejected (misaligned, out of range, illegal funct3)
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, req_ready=0 while rst_n low, rsp_valid=0,
//     rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not cleared.
//   FSM IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid&&req_ready latch write/addr/wdata/funct3;
//       go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else to RESP.
//     WAIT: req_ready=0. Decrement counter; when it reads 0, go to RESP.
//     RESP: rsp_valid=1 with rdata/err stable; hold until rsp_ready, then go to IDLE.
//   Latency: handshake in cycle N -> rsp_valid first high in cycle N+WAIT_CYCLES+1.
//     Minimum turnaround: next request accepted in the cycle after the response handshake.
//   Access commit: RAM read/write happens on the edge that enters RESP, exactly once.
//   Error checks (any -> rsp_err=1, no RAM write, rsp_rdata=0):
//     halfword (funct3[1:0]=01) with addr[0]=1; word (010) with addr[1:0]!=00;
//     word index addr[31:2] >= DEPTH; load funct3 in {011,110,111};
//     store funct3 not in {000,001,010}.
//   Little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1].
//   Loads: 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend
//     byte, 101 zero-extend half.
//   Stores: write only the addressed byte/half/word lanes; other lanes unchanged.
//     rsp_rdata=0 and rsp_err=0 for successful stores.
//   Request inputs are ignored outside IDLE; a held req_valid is not double-accepted.
//   Reset mid-operation: abandon the in-flight request and return to IDLE. A store not
//     yet committed is dropped; a committed store stays in the RAM.
// TESTING
//   SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0.
//   SB 0x11 data 0x80 over 0xDEADBEEF; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080;
//     LW 0x10 -> 0xDEAD80EF.
//   WAIT_CYCLES=2, accept in cycle 5 -> rsp_valid rises in cycle 8. Hold rsp_ready=0
//     for 3 cycles -> rsp_valid and rdata stable and req_ready=0 throughout.
//   LH 0x13, SW 0x12, LW at word DEPTH -> err=1, rdata=0. Then LW 0x10 -> RAM unchanged.
//   WAIT_CYCLES=0 back-to-back SW/LW with req_valid and rsp_ready held high ->
//     one response every 2 cycles, each request accepted once.
//   Pull rst_n low during WAIT of an SW to 0x20 -> rsp_valid=0 immediately;
//     after release, LW 0x20 returns the old value.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind valid/ready request/response channels.
// Handles RV32I load/store sizing, sign extension and a fixed number of wait states.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_sel_in;
  logic        w_write;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_funct3;
  logic        w_accept;
  logic        w_commit;
  logic [AW-1:0] w_idx;
  logic        w_oor;
  logic        w_misal;
  logic        w_bad_f3;
  logic        w_err;
  logic [31:0] w_word;
  logic [31:0] w_rdata_next;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign req_ready = rst_n && (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // With zero wait states the access commits on the accept edge, before the latch exists
  assign w_sel_in = (r_state == S_IDLE);
  assign w_write  = w_sel_in ? req_write  : r_write;
  assign w_addr   = w_sel_in ? req_addr   : r_addr;
  assign w_wdata  = w_sel_in ? req_wdata  : r_wdata;
  assign w_funct3 = w_sel_in ? req_funct3 : r_funct3;

  assign w_accept = req_valid && req_ready;
  assign w_commit = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_idx    = w_addr[AW+1:2];
  assign w_oor    = (w_addr[31:2] >= 30'(DEPTH));
  assign w_misal  = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_bad_f3 = w_write ? !(w_funct3 inside {3'b000, 3'b001, 3'b010})
                            :  (w_funct3 inside {3'b011, 3'b110, 3'b111});
  assign w_err    = w_oor || w_misal || w_bad_f3;

  assign w_word       = r_mem[w_idx];
  assign w_rdata_next = (w_err || w_write) ? 32'd0 : load_fmt(w_word, w_addr[1:0], w_funct3);
  assign w_be         = store_be(w_addr[1:0], w_funct3);
  assign w_wd         = store_data(w_wdata, w_funct3);

  always_ff @(posedge clk) begin
    if (w_commit && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_funct3    <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= w_rdata_next;
              r_err       <= w_err;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_rdata_next;
            r_err       <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with two wait states, one with none.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [2:0]  b_req_funct3;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_funct3(b_req_funct3), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int b_nrsp  = 0;
  int b_last  = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        ea = qa.pop_front();
        check("a_rdata", rsp_rdata, ea[31:0]);
        check("a_err", {31'd0, rsp_err}, {31'd0, ea[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rsp_valid && b_rsp_ready) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_rsp: got rdata 0x%08h err %0b, expected no response", b_rsp_rdata, b_rsp_err);
      end else begin
        eb = qb.pop_front();
        check("b_rdata", b_rsp_rdata, eb[31:0]);
        check("b_err", {31'd0, b_rsp_err}, {31'd0, eb[32]});
        if (b_nrsp > 0) check("b_spacing", 32'(cyc - b_last), 32'd2);
      end
      b_last = cyc;
      b_nrsp++;
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee);
    bit ok;
    ok = 0;
    qa.push_back({ee, er});
    req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3; req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL a_accept_timeout: got req_ready 0, expected 1 within 50 cycles");
      void'(qa.pop_back());
    end
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50 && qa.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (qa.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL a_rsp_timeout: got %0d pending, expected 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input logic [31:0] er, input logic ee);
    send(w, a, d, f3, er, ee);
    wait_rsp();
  endtask

  logic        bv_w  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] bv_a  [4] = '{32'h4, 32'h4, 32'h8, 32'h8};
  logic [31:0] bv_d  [4] = '{32'h11223344, 32'h0, 32'hA5A5A5A5, 32'h0};
  logic [31:0] bv_e  [4] = '{32'h0, 32'h11223344, 32'h0, 32'hA5A5A5A5};

  initial begin
    int lat;
    int bi;
    int b_acc;
    bit acc;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; rsp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_funct3 = 0; b_rsp_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_b_req_ready", {31'd0, b_req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    do_req(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    do_req(1, 32'h11, 32'h00000080, 3'b000, 32'h0, 0);
    do_req(0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 0);
    do_req(0, 32'h11, 32'h0, 3'b100, 32'h00000080, 0);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 0);
    do_req(0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
    do_req(0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);

    // Latency and backpressure hold
    rsp_ready = 1'b0;
    send(0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("latency", 32'(lat), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'hDEAD80EF);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      if (i < 2) @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_rsp();

    do_req(0, 32'h13, 32'h0, 3'b001, 32'h0, 1);
    do_req(1, 32'h12, 32'h55555555, 3'b010, 32'h0, 1);
    do_req(0, 32'h1000, 32'h0, 3'b010, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    do_req(1, 32'h10, 32'h55555555, 3'b100, 32'h0, 1);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 0);

    do_req(1, 32'h14, 32'h00000000, 3'b010, 32'h0, 0);
    do_req(1, 32'h16, 32'hFFFFABCD, 3'b001, 32'h0, 0);
    do_req(0, 32'h14, 32'h0, 3'b010, 32'hABCD0000, 0);
    do_req(0, 32'h17, 32'h0, 3'b000, 32'hFFFFFFAB, 0);

    // Reset while a store waits: the store must be dropped
    do_req(1, 32'h20, 32'h12345678, 3'b010, 32'h0, 0);
    send(1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 0);
    qa.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(0, 32'h20, 32'h0, 3'b010, 32'h12345678, 0);

    // Zero wait states, back-to-back with valid and ready held high
    bi = 0; b_acc = 0;
    b_req_write = bv_w[0]; b_req_addr = bv_a[0]; b_req_wdata = bv_d[0]; b_req_funct3 = 3'b010;
    b_req_valid = 1'b1;
    for (int i = 0; i < 40 && bi < 4; i++) begin
      @(negedge clk);
      acc = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      if (acc) begin
        qb.push_back({1'b0, bv_e[bi]});
        b_acc++;
        bi++;
        if (bi < 4) begin
          b_req_write = bv_w[bi]; b_req_addr = bv_a[bi]; b_req_wdata = bv_d[bi];
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    b_req_valid = 1'b0;
    for (int i = 0; i < 20 && qb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("b_accepts", 32'(b_acc), 32'd4);
    check("b_responses", 32'(b_nrsp), 32'd4);
    check("b_pending", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
